// File: rtl/retire_monitor_pkg.sv
// retire_monitor_pkg: shared types and constants for the retire monitor.
package retire_monitor_pkg;
    typedef enum logic [1:0] {CAUSE_NONE, CAUSE_ECALL, CAUSE_LOOP, CAUSE_STALL} cause_e;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;
    localparam logic [31:0] INSN_ECALL = 32'h00000073;
    localparam logic [31:0] CNT_MAX    = 32'hFFFFFFFF;
endpackage

// File: rtl/retire_monitor_sat_counter.sv
// sat_counter: up-counter that saturates at all-ones; clr with inc loads 1.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) value <= '0;
        else if (clr) value <= {{(WIDTH-1){1'b0}}, inc};
        else if (inc && value != '1) value <= value + 1'b1;
    end
endmodule

// File: rtl/retire_monitor.sv
// retire_monitor: watches the retire stream, detects ECALL/self-loop/deadlock,
// drains for DRAIN_CYCLES and then latches the verdict and frozen counts.
module retire_monitor
    import retire_monitor_pkg::*;
#(
    parameter int STALL_LIMIT  = 1000,
    parameter int LOOP_LIMIT   = 8,
    parameter int DRAIN_CYCLES = 4,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_pc,
    input  logic [31:0]     wb_insn,
    input  logic [XLEN-1:0] a0_value,
    output logic            done,
    output logic            pass,
    output logic [1:0]      cause,
    output logic [XLEN-1:0] exit_code,
    output logic [31:0]     cycle_count,
    output logic [31:0]     retire_count
);
    state_e          state_q;
    cause_e          cause_q, trig;
    logic [XLEN-1:0] exit_q, last_pc_q;
    logic [31:0]     drain_q, stall_ctr, loop_ctr;
    logic            active, is_ecall, same_pc, hit_loop, hit_stall;

    // Detection is disarmed once a cause is latched; the following RUN cycle
    // is a one-cycle hand-off before DRAIN so done lands DRAIN_CYCLES+1 edges later.
    assign active    = state_q == ST_RUN && cause_q == CAUSE_NONE;
    assign is_ecall  = wb_valid && wb_insn == INSN_ECALL;
    assign same_pc   = wb_valid && loop_ctr != '0 && wb_pc == last_pc_q;
    assign hit_loop  = wb_valid && (same_pc ? {1'b0, loop_ctr} + 33'd1 : 33'd1) >= 33'(LOOP_LIMIT);
    assign hit_stall = !wb_valid && {1'b0, stall_ctr} + 33'd1 >= 33'(STALL_LIMIT);
    assign trig      = is_ecall ? CAUSE_ECALL : hit_loop ? CAUSE_LOOP : hit_stall ? CAUSE_STALL : CAUSE_NONE;

    assign done      = state_q == ST_DONE;
    assign cause     = done ? cause_q : CAUSE_NONE;
    assign exit_code = done ? exit_q : '0;
    assign pass      = done && cause_q == CAUSE_ECALL && exit_q == '0;

    sat_counter #(.WIDTH(32)) u_cycle (
        .clk(clk), .rst(rst), .clr(1'b0),
        .inc(state_q == ST_RUN || state_q == ST_DRAIN), .value(cycle_count)
    );
    sat_counter #(.WIDTH(32)) u_retire (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(active && wb_valid), .value(retire_count)
    );
    sat_counter #(.WIDTH(32)) u_stall (
        .clk(clk), .rst(rst), .clr(active && wb_valid), .inc(active && !wb_valid), .value(stall_ctr)
    );
    sat_counter #(.WIDTH(32)) u_loop (
        .clk(clk), .rst(rst), .clr(active && wb_valid && !same_pc), .inc(active && wb_valid), .value(loop_ctr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            exit_q    <= '0;
            last_pc_q <= '0;
            drain_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: state_q <= ST_RUN;
                ST_RUN: begin
                    if (cause_q != CAUSE_NONE) state_q <= DRAIN_CYCLES == 0 ? ST_DONE : ST_DRAIN;
                    else begin
                        cause_q <= trig;
                        if (is_ecall) exit_q <= a0_value;
                        if (wb_valid) last_pc_q <= wb_pc;
                    end
                end
                ST_DRAIN: begin
                    drain_q <= drain_q + 32'd1;
                    if (drain_q == 32'(DRAIN_CYCLES - 1)) state_q <= ST_DONE;
                end
                default: ;
            endcase
        end
    end
endmodule
